// File: rtl/bram_reader_pkg.sv
// Shared defaults and types for the BRAM stream reader slice.
package bram_reader_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 11;
  localparam int unsigned DEFAULT_DATA_WIDTH = 15;
  localparam int unsigned BUF_DEPTH          = 3;

  typedef logic [DEFAULT_ADDR_WIDTH:0]   ptr_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;
  typedef logic [1:0]                    cnt_t;

endpackage

// File: rtl/stream_out_buf.sv
// Three-entry register FIFO feeding the valid/ready stream; head entry is
// always slot 0, so the output word comes straight from a register.
module stream_out_buf
  import bram_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  ready_i,
  input  logic                  flush_i,
  output cnt_t                  stored_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  cnt_t                  cnt_q, cnt_d, wr_idx;
  logic                  pop;

  assign pop = (cnt_q != '0) && ready_i;

  always_comb begin
    mem_d  = mem_q;
    cnt_d  = cnt_q;
    wr_idx = cnt_q - {1'b0, pop};
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i < BUF_DEPTH - 1; i++) begin
          mem_d[i] = mem_q[i+1];
        end
      end
      // Write lands after the shift, so capture+pop keeps the count steady.
      if (push_i && (wr_idx < 2'(BUF_DEPTH))) begin
        mem_d[wr_idx] = push_data_i;
      end
      cnt_d = wr_idx + {1'b0, push_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign stored_o  = cnt_q;
  assign m_valid_o = (cnt_q != '0);
  assign m_data_o  = mem_q[0];

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side BRAM controller: pointer/level tracking, credit-limited read
// issue, read-latency absorption and sticky overflow detection.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  input  logic                  flush,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  ovf
);

  localparam logic [ADDR_WIDTH:0] RAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                rd_vld_q;
  logic                ovf_q;
  cnt_t                stored;
  logic                pop;
  logic [2:0]          occ;

  assign level = wr_ptr - rd_ptr_q;
  assign pop   = m_valid && m_ready;
  assign occ   = {2'b0, rd_vld_q} + {1'b0, stored} - {2'b0, pop};
  assign enb   = !rst && !flush && (level != '0) && (occ < 3'd3);

  always_comb begin
    rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, enb};
    if (flush) rd_ptr_d = wr_ptr;
  end

  // Read-issue stage is enb itself; rd_vld_q is the doutb-valid stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      rd_vld_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      rd_vld_q <= enb;
      ovf_q    <= ovf_q | (level > RAM_DEPTH);
    end
  end

  stream_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (rd_vld_q && !flush),
    .push_data_i(doutb),
    .ready_i    (m_ready),
    .flush_i    (flush),
    .stored_o   (stored),
    .m_valid_o  (m_valid),
    .m_data_o   (m_data)
  );

  assign addrb  = rd_ptr_q[ADDR_WIDTH-1:0];
  assign rd_ptr = rd_ptr_q;
  assign ovf    = ovf_q;
  assign empty  = (level == '0) && !rd_vld_q && (stored == '0);

endmodule
